mul_iter32: RTL and testbench

- Multi-cycle unsigned WIDTH x WIDTH shift-add multiplier.
- Sits directly upstream of adder32: each cycle it drives one adder32 instance with the partial-product high word and the multiplicand, then consumes that adder's sum and carry to update its accumulator.
- Produces a 2*WIDTH-bit product through a valid/ready handshake.
- Intended as the NPC's MUL/MULHU execution unit.

---
 rtl/mul_iter32.sv | 120 ++++++++++++
 tb/tb_mul_iter32.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mul_iter32.sv
// Iterative shift-add unsigned multiplier, one add per cycle through adder32.
// Optional MUL_ZERO_SKIP_EN: zero operands bypass the iterations.
module adder32 (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        cin_i,
   output logic [31:0] sum_o,
   output logic        cout_o
);
   assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'd0, cin_i};
endmodule

module mul_iter32 #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 kill,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] acc_hi_q;
   logic [WIDTH-1:0] acc_lo_q;
   logic [CW-1:0]    cnt_q;

   logic [WIDTH-1:0] add_b_d;
   logic [WIDTH-1:0] sum_d;
   logic             carry_d;

   assign add_b_d = acc_lo_q[0] ? mcand_q : '0;

   adder32 u_add (
      .a_i    (acc_hi_q),
      .b_i    (add_b_d),
      .cin_i  (1'b0),
      .sum_o  (sum_d),
      .cout_o (carry_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         mcand_q     <= '0;
         acc_hi_q    <= '0;
         acc_lo_q    <= '0;
         cnt_q       <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               // kill outranks a new request arriving in the same cycle
               if (!kill && in_valid) begin
                  mcand_q    <= a;
                  acc_hi_q   <= '0;
                  acc_lo_q   <= b;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= BUSY;
`ifdef MUL_ZERO_SKIP_EN
                  if (a == '0 || b == '0) begin
                     acc_lo_q    <= '0;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end
`endif
               end
            end
            BUSY: begin
               if (kill) begin
                  in_ready_q <= 1'b1;
                  state_q    <= IDLE;
               end else begin
                  {acc_hi_q, acc_lo_q} <=
                     {carry_d, sum_d, acc_lo_q[WIDTH-1:1]};
                  cnt_q <= cnt_q + CW'(1);
                  if (cnt_q == LAST) begin
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end
               end
            end
            DONE: begin
               if (kill || out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = {acc_hi_q, acc_lo_q};
endmodule

// File: tb/tb_mul_iter32.sv
// Directed bench for mul_iter32: latency, products, backpressure,
// kill, asynchronous reset and zero operands.
module tb_mul_iter32;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        kill;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;

   int checks = 0;
   int errors = 0;

   mul_iter32 #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .kill      (kill),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns #1 after the accept edge, operands scrambled afterwards.
   task automatic start(input logic [31:0] ta, input logic [31:0] tb_v);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         step();
         n++;
      end
      chk("ready_before_start", 64'(in_ready), 64'd1);
      a = ta;
      b = tb_v;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      a = 32'hA5A5_5A5A;
      b = 32'h5A5A_A5A5;
   endtask

   task automatic wait_done(output int lat, output int rdy_seen);
      lat = 0;
      rdy_seen = 0;
      while (!out_valid && lat < 100) begin
         if (in_ready) rdy_seen++;
         step();
         lat++;
      end
      if (in_ready) rdy_seen++;
   endtask

   task automatic take();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   int lat;
   int rdy;
   int seen;

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      kill = 1'b0;
      out_ready = 1'b0;
      #12;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_result", result, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      step();

      // 3 * 5, exact 32-cycle latency
      start(32'd3, 32'd5);
      wait_done(lat, rdy);
      chk("lat_3x5", 64'(lat), 64'd32);
      chk("busy_ready_3x5", 64'(rdy), 64'd0);
      chk("res_3x5", result, 64'h0000_0000_0000_000F);
      take();
      chk("idle_after_3x5", 64'(in_ready), 64'd1);

      // carry on every iteration
      start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(lat, rdy);
      chk("lat_ff", 64'(lat), 64'd32);
      chk("res_ff", result, 64'hFFFF_FFFE_0000_0001);
      take();

      // backpressure
      start(32'h1234_5678, 32'h9ABC_DEF0);
      wait_done(lat, rdy);
      chk("lat_bp", 64'(lat), 64'd32);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_valid", 64'(out_valid), 64'd1);
         chk("bp_result", result, 64'h0B00_EA4E_242D_2080);
      end
      chk("bp_ready_low", 64'(in_ready), 64'd0);
      take();
      chk("bp_out_valid_drop", 64'(out_valid), 64'd0);
      chk("bp_in_ready", 64'(in_ready), 64'd1);
      chk("bp_result_kept", result, 64'h0B00_EA4E_242D_2080);

      // kill in IDLE beats in_valid
      a = 32'd6;
      b = 32'd6;
      in_valid = 1'b1;
      kill = 1'b1;
      step();
      in_valid = 1'b0;
      kill = 1'b0;
      chk("idle_kill_ready", 64'(in_ready), 64'd1);

      // kill at cnt=10
      start(32'd7, 32'd9);
      repeat (10) step();
      kill = 1'b1;
      step();
      kill = 1'b0;
      chk("kill_in_ready", 64'(in_ready), 64'd1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) seen++;
         step();
      end
      chk("kill_no_valid", 64'(seen), 64'd0);
      start(32'd2, 32'd4);
      wait_done(lat, rdy);
      chk("lat_2x4", 64'(lat), 64'd32);
      chk("res_2x4", result, 64'd8);
      take();

      // in_valid during BUSY ignored; async reset between edges
      start(32'd11, 32'd13);
      in_valid = 1'b1;
      repeat (5) step();
      in_valid = 1'b0;
      chk("busy_ignores_valid", 64'(in_ready), 64'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_result", result, 64'd0);
      #1;
      rst = 1'b0;
      step();

      // zero operand
      start(32'd0, 32'hDEAD_BEEF);
`ifdef MUL_ZERO_SKIP_EN
      step();
      chk("zero_skip_valid", 64'(out_valid), 64'd1);
`else
      wait_done(lat, rdy);
      chk("lat_zero", 64'(lat), 64'd32);
`endif
      chk("res_zero", result, 64'd0);
      take();
      chk("zero_idle", 64'(in_ready), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
